// File: rtl/lpc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lpc_pkg
// Purpose  : Shared constants and types for the LPC residual path. The
//            quantizer uses the same SHIFT and COEFF_W, so coefficients
//            move between the two blocks without rescaling.
// Contents : widths, pipeline tree geometry, FSM state type, order clamp.
// Revision : 1.0 - initial release
// ============================================================================
package lpc_pkg;

    localparam int MAX_ORDER  = 12;
    localparam int SHIFT      = 10;
    localparam int COEFF_W    = 15;
    localparam int SAMPLE_W   = 16;
    localparam int RES_W      = 32;
    localparam int ORDER_W    = 4;

    // Each coefficient times sample product is 31 bits. Twelve of these
    // summed without loss need 35 bits.
    localparam int PROD_W     = COEFF_W + SAMPLE_W;
    localparam int SUM_W      = 35;
    localparam int GROUP_SIZE = 3;
    localparam int NUM_GROUPS = MAX_ORDER / GROUP_SIZE;

    localparam logic [ORDER_W-1:0] c_MAX_ORDER = ORDER_W'(MAX_ORDER);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } lpc_state_e;

    function automatic logic [ORDER_W-1:0] clamp_order(input logic [ORDER_W-1:0] order);
        return (order > c_MAX_ORDER) ? c_MAX_ORDER : order;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lpc_mac_tree.sv
`default_nettype none
// ============================================================================
// Module   : lpc_mac_tree
// Purpose  : Registered 12-way multiply followed by a two-level adder tree.
//            Level 1 is four registered partial sums of three products.
//            Level 2 is the combinational final sum of those partials.
//            Everything holds while iEnable is low.
// Ports    : iClock, iReset (sync, active-high), iEnable
//            iCoeffs  - MAX_ORDER packed signed coefficients, slot 0 in LSBs
//            iHist    - MAX_ORDER packed signed samples, x[n-1] in LSBs
//            oSum     - signed SUM_W sum, valid two enabled edges after inputs
// Revision : 1.0 - initial release
// ============================================================================
module lpc_mac_tree
    import lpc_pkg::*;
(
    input  logic                          iClock,
    input  logic                          iReset,
    input  logic                          iEnable,
    input  logic [MAX_ORDER*COEFF_W-1:0]  iCoeffs,
    input  logic [MAX_ORDER*SAMPLE_W-1:0] iHist,
    output logic [SUM_W-1:0]              oSum
);

    logic signed [PROD_W-1:0] w_prod [MAX_ORDER];
    logic signed [PROD_W-1:0] r_prod [MAX_ORDER];
    logic signed [SUM_W-1:0]  w_part [NUM_GROUPS];
    logic signed [SUM_W-1:0]  r_part [NUM_GROUPS];
    logic signed [SUM_W-1:0]  w_total;

    always_comb begin
        for (int i = 0; i < MAX_ORDER; i++) begin
            w_prod[i] = PROD_W'($signed(iCoeffs[i*COEFF_W +: COEFF_W]))
                      * PROD_W'($signed(iHist[i*SAMPLE_W +: SAMPLE_W]));
        end
    end

    generate
        for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
            assign w_part[g] = SUM_W'(r_prod[g*GROUP_SIZE])
                             + SUM_W'(r_prod[g*GROUP_SIZE+1])
                             + SUM_W'(r_prod[g*GROUP_SIZE+2]);
        end
    endgenerate

    always_ff @(posedge iClock) begin
        if (iReset) begin
            for (int i = 0; i < MAX_ORDER; i++)  r_prod[i] <= '0;
            for (int g = 0; g < NUM_GROUPS; g++) r_part[g] <= '0;
        end else if (iEnable) begin
            for (int i = 0; i < MAX_ORDER; i++)  r_prod[i] <= w_prod[i];
            for (int g = 0; g < NUM_GROUPS; g++) r_part[g] <= w_part[g];
        end
    end

    always_comb begin
        w_total = '0;
        for (int g = 0; g < NUM_GROUPS; g++) w_total = w_total + r_part[g];
    end

    assign oSum = w_total;

endmodule
`default_nettype wire

// File: rtl/lpc_residual.sv
`default_nettype none
// ============================================================================
// Module   : lpc_residual
// Purpose  : Applies quantized LPC coefficients to the PCM stream and emits
//            FLAC residuals. The first order samples of a frame are passed
//            through verbatim as warm-up samples.
//            Pipeline: S1 history select, S2 products, S3 partial sums,
//            then output (final sum, shift, subtract). Latency is 4 enabled
//            edges.
// Ports    : iClock, iReset (sync, active-high), iEnable (global freeze)
//            iCoeffValid/iCoeffIdx/iCoeff - shadow bank write
//            iCommit/iOrder               - arm shadow bank for next frame
//            iValid/iFrameStart/iSample   - sample stream
//            oValid/oResidual/oWarmup     - result stream
//            oPending                     - committed bank awaiting frame start
// Revision : 1.0 - initial release
// ============================================================================
module lpc_residual
    import lpc_pkg::*;
(
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iEnable,
    input  logic                iCoeffValid,
    input  logic [3:0]          iCoeffIdx,
    input  logic [COEFF_W-1:0]  iCoeff,
    input  logic                iCommit,
    input  logic [3:0]          iOrder,
    input  logic                iValid,
    input  logic                iFrameStart,
    input  logic [SAMPLE_W-1:0] iSample,
    output logic                oValid,
    output logic [RES_W-1:0]    oResidual,
    output logic                oWarmup,
    output logic                oPending
);

    logic [COEFF_W-1:0]  r_shadow      [MAX_ORDER];
    logic [COEFF_W-1:0]  r_active      [MAX_ORDER];
    logic [COEFF_W-1:0]  w_shadow_next [MAX_ORDER];
    logic [SAMPLE_W-1:0] r_hist        [MAX_ORDER];

    logic [ORDER_W-1:0] r_pend_order, r_active_order, r_warm_cnt;
    logic [ORDER_W-1:0] w_commit_order, w_pend_order_eff, w_order_use;
    logic [ORDER_W-1:0] w_cnt_use, w_cnt_next;
    logic               r_pending;
    lpc_state_e         r_state, w_state_use, w_state_next;

    logic w_frame_start, w_accept, w_swap, w_pend_eff, w_is_warm;

    logic [MAX_ORDER*SAMPLE_W-1:0] w_sel_hist, r_s1_hist;
    logic [MAX_ORDER*COEFF_W-1:0]  w_active_flat;

    logic                       r_s1_valid, r_s2_valid, r_s3_valid;
    logic                       r_s1_warm,  r_s2_warm,  r_s3_warm;
    logic signed [SAMPLE_W-1:0] r_s1_x,     r_s2_x,     r_s3_x;
    logic signed [SUM_W-1:0]    w_sum;
    logic signed [RES_W-1:0]    w_pred, w_res;

    assign oPending = r_pending;

    generate
        for (genvar g = 0; g < MAX_ORDER; g++) begin : g_flat
            assign w_active_flat[g*COEFF_W +: COEFF_W] = r_active[g];
        end
    endgenerate

    // Control and next-state logic. A write or commit in the same cycle as
    // a frame start is folded in, so it takes effect for that frame.
    always_comb begin
        w_shadow_next = r_shadow;
        if (iCoeffValid && (iCoeffIdx < c_MAX_ORDER)) begin
            w_shadow_next[iCoeffIdx] = iCoeff;
        end

        w_commit_order   = clamp_order(iOrder);
        w_pend_eff       = r_pending | iCommit;
        w_pend_order_eff = iCommit ? w_commit_order : r_pend_order;

        w_frame_start = iValid & iFrameStart;
        w_accept      = iValid & (iFrameStart | (r_state != IDLE));
        w_swap        = w_frame_start & w_pend_eff;
        w_order_use   = w_swap ? w_pend_order_eff : r_active_order;

        if (w_frame_start) begin
            w_cnt_use   = '0;
            w_state_use = (w_order_use == '0) ? RUN : WARMUP;
        end else begin
            w_cnt_use   = r_warm_cnt;
            w_state_use = r_state;
        end

        w_is_warm    = (w_state_use == WARMUP);
        w_cnt_next   = w_cnt_use;
        w_state_next = w_state_use;
        if (w_is_warm) begin
            w_cnt_next = w_cnt_use + 1'b1;
            if (w_cnt_next == w_order_use) w_state_next = RUN;
        end

        // Slots at or beyond the order see zero history, so any stale
        // coefficients in those slots drop out of the sum. A frame start
        // sees an all-zero history.
        w_sel_hist = '0;
        for (int j = 0; j < MAX_ORDER; j++) begin
            if (!w_frame_start && (ORDER_W'(j) < w_order_use)) begin
                w_sel_hist[j*SAMPLE_W +: SAMPLE_W] = r_hist[j];
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state    <= IDLE;
            r_warm_cnt <= '0;
        end else if (iEnable && w_accept) begin
            r_state    <= w_state_next;
            r_warm_cnt <= w_cnt_next;
        end
    end

    // Coefficient banks. The active bank is only replaced on a frame
    // start. The last sample of the previous frame reads the old bank when
    // it enters the product stage on that same edge.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            for (int i = 0; i < MAX_ORDER; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_pend_order   <= '0;
            r_active_order <= '0;
            r_pending      <= 1'b0;
        end else if (iEnable) begin
            r_shadow <= w_shadow_next;
            if (w_swap) begin
                r_active       <= w_shadow_next;
                r_active_order <= w_pend_order_eff;
                r_pending      <= 1'b0;
            end else if (iCommit) begin
                r_pend_order <= w_commit_order;
                r_pending    <= 1'b1;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            for (int i = 0; i < MAX_ORDER; i++) r_hist[i] <= '0;
        end else if (iEnable && w_accept) begin
            r_hist[0] <= iSample;
            for (int i = 1; i < MAX_ORDER; i++) begin
                r_hist[i] <= w_frame_start ? '0 : r_hist[i-1];
            end
        end
    end

    lpc_mac_tree u_mac_tree (
        .iClock  (iClock),
        .iReset  (iReset),
        .iEnable (iEnable),
        .iCoeffs (w_active_flat),
        .iHist   (r_s1_hist),
        .oSum    (w_sum)
    );

    // The floor shift leaves a value of at most 25 bits, so truncating it to
    // RES_W loses nothing.
    assign w_pred = RES_W'(w_sum >>> SHIFT);
    assign w_res  = RES_W'(r_s3_x) - w_pred;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s1_warm  <= 1'b0;
            r_s2_warm  <= 1'b0;
            r_s3_warm  <= 1'b0;
            r_s1_x     <= '0;
            r_s2_x     <= '0;
            r_s3_x     <= '0;
            r_s1_hist  <= '0;
            oValid     <= 1'b0;
            oResidual  <= '0;
            oWarmup    <= 1'b0;
        end else if (iEnable) begin
            r_s1_valid <= w_accept;
            r_s1_warm  <= w_accept & w_is_warm;
            r_s1_x     <= iSample;
            r_s1_hist  <= w_sel_hist;
            r_s2_valid <= r_s1_valid;
            r_s2_warm  <= r_s1_warm;
            r_s2_x     <= r_s1_x;
            r_s3_valid <= r_s2_valid;
            r_s3_warm  <= r_s2_warm;
            r_s3_x     <= r_s2_x;
            oValid     <= r_s3_valid;
            if (r_s3_valid) begin
                oResidual <= r_s3_warm ? RES_W'(r_s3_x) : w_res;
                oWarmup   <= r_s3_warm;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lpc_residual.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpc_residual
// Purpose  : Directed, self-checking bench for lpc_residual. Table rows hold
//            stimulus plus hand-computed results. Freeze and reset corner
//            cases are written out as explicit sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lpc_residual;

    logic        iClock;
    logic        iReset;
    logic        iEnable;
    logic        iCoeffValid;
    logic [3:0]  iCoeffIdx;
    logic [14:0] iCoeff;
    logic        iCommit;
    logic [3:0]  iOrder;
    logic        iValid;
    logic        iFrameStart;
    logic [15:0] iSample;
    logic        oValid;
    logic [31:0] oResidual;
    logic        oWarmup;
    logic        oPending;

    int checks = 0;
    int errors = 0;

    lpc_residual dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iEnable     (iEnable),
        .iCoeffValid (iCoeffValid),
        .iCoeffIdx   (iCoeffIdx),
        .iCoeff      (iCoeff),
        .iCommit     (iCommit),
        .iOrder      (iOrder),
        .iValid      (iValid),
        .iFrameStart (iFrameStart),
        .iSample     (iSample),
        .oValid      (oValid),
        .oResidual   (oResidual),
        .oWarmup     (oWarmup),
        .oPending    (oPending)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    typedef struct {
        logic               v;
        logic               fs;
        logic signed [15:0] x;
        logic               cv;
        logic [3:0]         cidx;
        logic signed [14:0] c;
        logic               cm;
        logic [3:0]         ord;
        logic               ev;
        logic signed [31:0] eres;
        logic               ew;
        logic               ep;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t smp(input logic fs, input int x, input logic ew,
                                 input int eres, input logic ep);
        vec_t r;
        r.v = 1'b1; r.fs = fs; r.x = 16'(x);
        r.cv = 1'b0; r.cidx = 4'd0; r.c = 15'd0; r.cm = 1'b0; r.ord = 4'd0;
        r.ev = 1'b1; r.eres = eres; r.ew = ew; r.ep = ep;
        return r;
    endfunction

    function automatic vec_t cfg(input logic cv, input int idx, input int c,
                                 input logic cm, input int ord, input logic ep);
        vec_t r;
        r.v = 1'b0; r.fs = 1'b0; r.x = 16'd0;
        r.cv = cv; r.cidx = 4'(idx); r.c = 15'(c); r.cm = cm; r.ord = 4'(ord);
        r.ev = 1'b0; r.eres = 0; r.ew = 1'b0; r.ep = ep;
        return r;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic drive_idle();
        iCoeffValid = 1'b0; iCoeffIdx = 4'd0; iCoeff = 15'd0;
        iCommit = 1'b0; iOrder = 4'd0;
        iValid = 1'b0; iFrameStart = 1'b0; iSample = 16'd0;
    endtask

    task automatic apply(input vec_t r);
        iCoeffValid = r.cv; iCoeffIdx = r.cidx; iCoeff = r.c;
        iCommit = r.cm; iOrder = r.ord;
        iValid = r.v; iFrameStart = r.fs; iSample = r.x;
    endtask

    // Row i's result appears 3 steps after the step that accepts it.
    task automatic run_table();
        int n;
        vec_t r;
        n = tv.size();
        for (int i = 0; i < n + 3; i++) begin
            if (i < n) apply(tv[i]); else drive_idle();
            step();
            if (i < n) chk($sformatf("row%0d_pending", i), oPending, tv[i].ep);
            if (i >= 3) begin
                r = tv[i-3];
                chk($sformatf("row%0d_valid", i-3), oValid, r.ev);
                if (r.ev) begin
                    chk($sformatf("row%0d_residual", i-3), oResidual, r.eres);
                    chk($sformatf("row%0d_warmup", i-3), oWarmup, r.ew);
                end
            end
        end
        drive_idle();
        tv.delete();
    endtask

    initial begin
        vec_t r;
        drive_idle();
        iEnable = 1'b1;
        iReset  = 1'b1;
        step();
        step();
        chk("reset_valid", oValid, 0);
        chk("reset_residual", oResidual, 0);
        chk("reset_warmup", oWarmup, 0);
        chk("reset_pending", oPending, 0);
        iReset = 1'b0;

        // Order 1, c0 = 1024: 100, 105, 103 -> 100w, 5, -2
        tv.push_back(cfg(1, 0, 1024, 0, 0, 0));
        tv.push_back(cfg(0, 0, 0, 1, 1, 1));
        tv.push_back(smp(1, 100, 1, 100, 0));
        tv.push_back(smp(0, 105, 0, 5, 0));
        tv.push_back(smp(0, 103, 0, -2, 0));
        // Order 2, c = {2048, -1024}: 1, 2, 3, 4 -> 1w, 2w, 0, 0
        tv.push_back(cfg(1, 0, 2048, 0, 0, 0));
        tv.push_back(cfg(1, 1, -1024, 0, 0, 0));
        tv.push_back(cfg(0, 0, 0, 1, 2, 1));
        tv.push_back(smp(1, 1, 1, 1, 0));
        tv.push_back(smp(0, 2, 1, 2, 0));
        tv.push_back(smp(0, 3, 0, 0, 0));
        tv.push_back(smp(0, 4, 0, 0, 0));
        // Floor: order 1, c0 = 512 (write+commit together): -3w, then 0 -> 2
        tv.push_back(cfg(1, 0, 512, 1, 1, 1));
        tv.push_back(smp(1, -3, 1, -3, 0));
        tv.push_back(smp(0, 0, 0, 2, 0));
        // Mid-frame commit of c0 = 0 leaves the current frame on c0 = 512
        tv.push_back(smp(1, 10, 1, 10, 0));
        tv.push_back(smp(0, 20, 0, 15, 0));
        tv.push_back(cfg(1, 0, 0, 0, 0, 0));
        tv.push_back(cfg(0, 0, 0, 1, 1, 1));
        tv.push_back(smp(0, 30, 0, 20, 1));
        tv.push_back(smp(1, 40, 1, 40, 0));
        tv.push_back(smp(0, 50, 0, 50, 0));
        // Commit of c0 = 2048 coincident with frame start applies at once
        r = smp(1, 7, 1, 7, 0);
        r.cv = 1'b1; r.cidx = 4'd0; r.c = 15'sd2048; r.cm = 1'b1; r.ord = 4'd1;
        tv.push_back(r);
        tv.push_back(smp(0, 9, 0, -5, 0));
        run_table();

        // Freeze: order 1, c0 = 2048, samples 1..4 -> 1w, 0, -1, -2
        iValid = 1'b1; iFrameStart = 1'b1; iSample = 16'd1;
        step();
        iFrameStart = 1'b0;
        iSample = 16'd2; step();
        iSample = 16'd3; step();
        iSample = 16'd4; step();
        chk("pre_freeze_valid", oValid, 1);
        chk("pre_freeze_residual", oResidual, 1);
        iEnable = 1'b0;
        iSample = 16'd99;
        iCoeffValid = 1'b1; iCoeffIdx = 4'd0; iCoeff = 15'd0;
        iCommit = 1'b1; iOrder = 4'd1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("freeze%0d_valid", k), oValid, 1);
            chk($sformatf("freeze%0d_residual", k), oResidual, 1);
            chk($sformatf("freeze%0d_warmup", k), oWarmup, 1);
            chk($sformatf("freeze%0d_pending", k), oPending, 0);
        end
        drive_idle();
        iEnable = 1'b1;
        step();
        chk("resume0_valid", oValid, 1);
        chk("resume0_residual", oResidual, 0);
        chk("resume0_warmup", oWarmup, 0);
        step();
        chk("resume1_residual", oResidual, -1);
        step();
        chk("resume2_residual", oResidual, -2);
        step();
        chk("resume_drain_valid", oValid, 0);

        // Index 13 write is dropped: c0 stays 2048 -> 10w, 0
        tv.push_back(cfg(1, 13, 5000, 1, 1, 1));
        tv.push_back(smp(1, 10, 1, 10, 0));
        tv.push_back(smp(0, 20, 0, 0, 0));
        run_table();

        // Reset mid-frame with a commit pending
        iValid = 1'b1; iFrameStart = 1'b1; iSample = 16'd5;
        step();
        iFrameStart = 1'b0; iSample = 16'd6; iCommit = 1'b1; iOrder = 4'd1;
        step();
        chk("prereset_pending", oPending, 1);
        drive_idle();
        iReset = 1'b1;
        step();
        iReset = 1'b0;
        chk("midreset_valid", oValid, 0);
        chk("midreset_residual", oResidual, 0);
        chk("midreset_warmup", oWarmup, 0);
        chk("midreset_pending", oPending, 0);
        iValid = 1'b1; iSample = 16'd7;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("idle_ignore%0d_valid", k), oValid, 0);
        end
        // After reset the active order is 0: residual equals the sample
        iFrameStart = 1'b1; iSample = 16'd8;
        step();
        drive_idle();
        step();
        step();
        step();
        chk("order0_valid", oValid, 1);
        chk("order0_residual", oResidual, 8);
        chk("order0_warmup", oWarmup, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
